// File: rtl/cpu_pkg.sv
// Shared types for the RV32I multi-cycle control path.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [2:0] {
        ALU_NOP,
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_OR,
        ALU_AND
    } alu_op_t;

    typedef enum logic {
        SRC_A_RS1,
        SRC_A_PC
    } src_a_t;

    typedef enum logic {
        SRC_B_RS2,
        SRC_B_IMM
    } src_b_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_t;

    typedef enum logic {
        WRITE_DISABLE,
        WRITE_ENABLE
    } reg_write_t;

    typedef struct packed {
        alu_op_t    alu_op;
        src_a_t     src_a;
        src_b_t     src_b;
        imm_sel_t   imm_sel;
        reg_write_t reg_write;
    } control_signals_t;

    localparam control_signals_t CTRL_NOP = '{
        alu_op:    ALU_NOP,
        src_a:     SRC_A_RS1,
        src_b:     SRC_B_RS2,
        imm_sel:   IMM_I,
        reg_write: WRITE_DISABLE
    };

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB,
        TRAP
    } ctrl_state_t;

    typedef enum logic {
        PC_PLUS4,
        PC_TARGET
    } pc_sel_t;

    // Base opcodes recognised by this datapath.
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    // Coarse instruction class the sequencer needs to pick its path.
    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_FENCE,
        CLS_OTHER
    } instr_class_t;

    function automatic instr_class_t instr_class(input logic [6:0] opcode);
        instr_class_t cls;
        case (opcode)
            OPC_OP, OPC_OP_IMM: cls = CLS_ALU;
            OPC_LOAD:           cls = CLS_LOAD;
            OPC_STORE:          cls = CLS_STORE;
            OPC_BRANCH:         cls = CLS_BRANCH;
            OPC_MISC_MEM:       cls = CLS_FENCE;
            default:            cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I subset decoder: instruction word -> datapath controls + illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; reg_write is per-opcode intent, gated to WB by the sequencer.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [31:0]      instr,
    output control_signals_t ctrl,
    output logic             illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    alu_op_t    f3_op;
    logic       f3_ok;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7_b5   = instr[30];
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // funct3 -> ALU operation shared by OP and OP_IMM; shifts and compares are unsupported
    always_comb begin
        f3_op = ALU_NOP;
        f3_ok = 1'b1;
        case (funct3)
            3'b000:  f3_op = ALU_ADD;
            3'b100:  f3_op = ALU_XOR;
            3'b110:  f3_op = ALU_OR;
            3'b111:  f3_op = ALU_AND;
            default: f3_ok = 1'b0;
        endcase
    end

    // Opcode decode; anything unrecognised yields CTRL_NOP with illegal set
    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (f3_ok) begin
                    ctrl.alu_op    = (funct3 == 3'b000 && funct7_b5) ? ALU_SUB : f3_op;
                    ctrl.src_b     = SRC_B_RS2;
                    ctrl.reg_write = WRITE_ENABLE;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                // No SUBI exists, so bit 30 is just immediate data here
                if (f3_ok) begin
                    ctrl.alu_op    = f3_op;
                    ctrl.src_b     = SRC_B_IMM;
                    ctrl.imm_sel   = IMM_I;
                    ctrl.reg_write = WRITE_ENABLE;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.src_b     = SRC_B_IMM;
                ctrl.imm_sel   = IMM_I;
                ctrl.reg_write = WRITE_ENABLE;
            end
            OPC_STORE: begin
                ctrl.alu_op  = ALU_ADD;
                ctrl.src_b   = SRC_B_IMM;
                ctrl.imm_sel = IMM_S;
            end
            OPC_BRANCH: begin
                ctrl.alu_op  = ALU_SUB;
                ctrl.src_b   = SRC_B_RS2;
                ctrl.imm_sel = IMM_B;
            end
            OPC_MISC_MEM: begin
                ctrl = CTRL_NOP;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer owning all datapath write enables.
// Latency: 3 (branch/fence), 4 (ALU, store), 5 (load) cycles with zero-wait memory.
// Backpressure: imem/dmem requests are held until ready; each wait cycle adds one cycle.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_IR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic [31:0]      instr,
    output control_signals_t ctrl,
    output logic             pc_we,
    output pc_sel_t          pc_sel,
    output logic             instret,
    output logic             illegal
);

    ctrl_state_t      state_q;
    logic [31:0]      ir_q;
    control_signals_t ctrl_q;
    logic             imem_req_q;
    logic             dmem_req_q;
    logic             dmem_we_q;
    logic             illegal_q;

    control_signals_t dec_ctrl;
    control_signals_t dec_ctrl_gated;
    logic             dec_illegal;
    instr_class_t     cls;
    logic             imem_hs;
    logic             dmem_hs;
    logic             retire;

    instr_decoder u_dec (
        .instr   (ir_q),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    assign cls     = instr_class(ir_q[6:0]);
    assign imem_hs = imem_req_q & imem_ready;
    assign dmem_hs = dmem_req_q & dmem_ready;

    // Decoder output with the register write held off until WB
    always_comb begin
        dec_ctrl_gated           = dec_ctrl;
        dec_ctrl_gated.reg_write = WRITE_DISABLE;
    end

    // Retire strobe: store retirement and branch direction depend on same-cycle
    // inputs (dmem_ready, branch_taken), so this one is decoded, not registered
    always_comb begin
        retire = 1'b0;
        case (state_q)
            EXECUTE: retire = (cls == CLS_BRANCH) || (cls == CLS_FENCE);
            MEM:     retire = dmem_hs && dmem_we_q;
            WB:      retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    // Sequencer: state, instruction register, registered controls and requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            ir_q       <= RESET_IR;
            ctrl_q     <= CTRL_NOP;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    // Request is raised on entry (or one cycle after reset) and held to completion
                    if (imem_hs) begin
                        ir_q       <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= DECODE;
                    end else begin
                        imem_req_q <= 1'b1;
                    end
                end
                DECODE: begin
                    ctrl_q <= dec_ctrl_gated;
                    if (dec_illegal) begin
                        illegal_q <= 1'b1;
                        state_q   <= TRAP;
                    end else begin
                        state_q <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    case (cls)
                        CLS_LOAD, CLS_STORE: begin
                            dmem_req_q <= 1'b1;
                            dmem_we_q  <= (cls == CLS_STORE);
                            state_q    <= MEM;
                        end
                        CLS_BRANCH, CLS_FENCE: begin
                            ctrl_q     <= CTRL_NOP;
                            imem_req_q <= 1'b1;
                            state_q    <= FETCH;
                        end
                        default: begin
                            ctrl_q.reg_write <= dec_ctrl.reg_write;
                            state_q          <= WB;
                        end
                    endcase
                end
                MEM: begin
                    if (dmem_hs) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (dmem_we_q) begin
                            ctrl_q     <= CTRL_NOP;
                            imem_req_q <= 1'b1;
                            state_q    <= FETCH;
                        end else begin
                            ctrl_q.reg_write <= dec_ctrl.reg_write;
                            state_q          <= WB;
                        end
                    end
                end
                WB: begin
                    ctrl_q     <= CTRL_NOP;
                    imem_req_q <= 1'b1;
                    state_q    <= FETCH;
                end
                TRAP: begin
                    state_q <= TRAP;
                end
                default: begin
                    illegal_q <= 1'b1;
                    state_q   <= TRAP;
                end
            endcase
        end
    end

    assign imem_req = imem_req_q;
    assign dmem_req = dmem_req_q;
    assign dmem_we  = dmem_we_q;
    assign instr    = ir_q;
    assign ctrl     = ctrl_q;
    assign illegal  = illegal_q;
    assign pc_we    = retire;
    assign instret  = retire;
    assign pc_sel   = (state_q == EXECUTE && cls == CLS_BRANCH && branch_taken) ? PC_TARGET : PC_PLUS4;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction cycle traces against hand-computed values.
// Latency: n/a (testbench).
// Backpressure: memory ready inputs are delayed by per-vector wait counts.
module tb_multicycle_ctrl;
    import cpu_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             imem_ready = 1'b0;
    logic [31:0]      imem_rdata = 32'h0;
    logic             dmem_ready = 1'b0;
    logic             branch_taken = 1'b0;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic [31:0]      instr;
    control_signals_t ctrl;
    logic             pc_we;
    pc_sel_t          pc_sel;
    logic             instret;
    logic             illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.RESET_IR(32'h0000_0013)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .branch_taken (branch_taken),
        .instr        (instr),
        .ctrl         (ctrl),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .instret      (instret),
        .illegal      (illegal)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        int lat;      // cycle of instret (0 = none)
        int pcwe;     // number of pc_we cycles
        int pcwe_cyc; // cycle of last pc_we
        int sel;      // pc_sel while pc_we
        int rw;       // reg_write cycles
        int rw_cyc;   // cycle of last reg_write
        int alu;      // ctrl.alu_op in EXECUTE
        int srcb;     // ctrl.src_b in EXECUTE
        int dreq;     // dmem_req cycles
        int dwe;      // dmem_req & dmem_we cycles
        int ireq_ok;  // imem_req held until handshake
        int ir_ok;    // IR unchanged while waiting, loaded right after handshake
        int ill_cyc;  // first cycle illegal seen
    } res_t;

    // Runs one instruction from its first FETCH cycle (cycle 1); stops on retire or trap.
    task automatic run(input logic [31:0] word, input int fwait, input int mwait,
                       input bit taken, input int rst_at, output res_t r);
        int          freq = 0;
        int          dseen = 0;
        int          hc = -10;
        bit          fetched = 1'b0;
        bit          hs_prev = 1'b0;
        logic [31:0] ir0;
        r = '{default: 0};
        r.ireq_ok = 1;
        r.ir_ok = 1;
        ir0 = instr;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #2;
            imem_ready   = imem_req && !fetched && (freq >= fwait);
            imem_rdata   = imem_ready ? word : 32'hDEAD_BEEF;
            dmem_ready   = dmem_req && (dseen >= mwait);
            branch_taken = taken;
            if (rst_at == c) begin
                #1;
                r.dreq = int'(dmem_req);
                rst_n = 1'b0;
                #1;
                check("rst_async_dmem_req", 32'(dmem_req), 32'd0);
                check("rst_no_instret", 32'(instret), 32'd0);
                check("rst_no_pc_we", 32'(pc_we), 32'd0);
                return;
            end
            #3;
            if (!fetched) begin
                if (!imem_req) r.ireq_ok = 0;
                if (instr !== ir0) r.ir_ok = 0;
                freq++;
            end else if (hs_prev && instr !== word) begin
                r.ir_ok = 0;
            end
            hs_prev = imem_req && imem_ready;
            if (hs_prev) begin
                fetched = 1'b1;
                hc = c;
            end
            if (dmem_req) begin
                dseen++;
                r.dreq++;
                if (dmem_we) r.dwe++;
            end
            if (ctrl.reg_write == WRITE_ENABLE) begin
                r.rw++;
                r.rw_cyc = c;
            end
            if (c == hc + 2) begin
                r.alu  = int'(ctrl.alu_op);
                r.srcb = int'(ctrl.src_b);
            end
            if (pc_we) begin
                r.pcwe++;
                r.pcwe_cyc = c;
                r.sel = int'(pc_sel);
            end
            if (instret) begin
                r.lat = c;
                break;
            end
            if (illegal) begin
                r.ill_cyc = c;
                break;
            end
        end
    endtask

    res_t r;
    int   ireq_cnt;
    int   ill_cnt;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_pc_we", 32'(pc_we), 32'd0);
        check("rst_instret", 32'(instret), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'(CTRL_NOP));
        check("rst_instr", instr, 32'h0000_0013);
        rst_n = 1'b1;
        #1;
        check("rel_imem_req_not_yet", 32'(imem_req), 32'd0);

        // ADD x3,x1,x2 zero wait
        run(32'h002081B3, 0, 0, 1'b0, 0, r);
        check("add_lat", r.lat, 4);
        check("add_alu", r.alu, int'(ALU_ADD));
        check("add_srcb", r.srcb, int'(SRC_B_RS2));
        check("add_rw_cnt", r.rw, 1);
        check("add_rw_cyc", r.rw_cyc, 4);
        check("add_pcwe_cnt", r.pcwe, 1);
        check("add_pcwe_cyc", r.pcwe_cyc, 4);
        check("add_sel", r.sel, int'(PC_PLUS4));
        check("add_ir", r.ir_ok, 1);

        // ADD with imem_ready low for 3 cycles
        run(32'h002081B3, 3, 0, 1'b0, 0, r);
        check("fwait_lat", r.lat, 7);
        check("fwait_ireq_held", r.ireq_ok, 1);
        check("fwait_ir", r.ir_ok, 1);
        check("fwait_rw_cyc", r.rw_cyc, 7);

        // SUB x3,x1,x2
        run(32'h402081B3, 0, 0, 1'b0, 0, r);
        check("sub_alu", r.alu, int'(ALU_SUB));
        check("sub_lat", r.lat, 4);

        // XORI x3,x1,5
        run(32'h0050C193, 0, 0, 1'b0, 0, r);
        check("xori_alu", r.alu, int'(ALU_XOR));
        check("xori_srcb", r.srcb, int'(SRC_B_IMM));
        check("xori_lat", r.lat, 4);

        // LW x3,0(x1) with dmem_ready delayed 2 cycles
        run(32'h0000A183, 0, 2, 1'b0, 0, r);
        check("lw_dreq_cnt", r.dreq, 3);
        check("lw_dwe_cnt", r.dwe, 0);
        check("lw_rw_cyc", r.rw_cyc, 7);
        check("lw_rw_cnt", r.rw, 1);
        check("lw_lat", r.lat, 7);
        check("lw_alu", r.alu, int'(ALU_ADD));
        check("lw_srcb", r.srcb, int'(SRC_B_IMM));

        // SW x2,0(x1) zero wait
        run(32'h0020A023, 0, 0, 1'b0, 0, r);
        check("sw_lat", r.lat, 4);
        check("sw_dreq_cnt", r.dreq, 1);
        check("sw_dwe_cnt", r.dwe, 1);
        check("sw_rw_cnt", r.rw, 0);
        check("sw_pcwe_cyc", r.pcwe_cyc, 4);

        // BEQ x1,x2,8 taken, then not taken
        run(32'h00208463, 0, 0, 1'b1, 0, r);
        check("beq_t_lat", r.lat, 3);
        check("beq_t_sel", r.sel, int'(PC_TARGET));
        check("beq_t_rw", r.rw, 0);
        check("beq_t_alu", r.alu, int'(ALU_SUB));
        run(32'h00208463, 0, 0, 1'b0, 0, r);
        check("beq_nt_lat", r.lat, 3);
        check("beq_nt_sel", r.sel, int'(PC_PLUS4));
        check("beq_nt_pcwe_cyc", r.pcwe_cyc, 3);
        check("beq_nt_rw", r.rw, 0);

        // FENCE
        run(32'h0000000F, 0, 0, 1'b0, 0, r);
        check("fence_lat", r.lat, 3);
        check("fence_alu", r.alu, int'(ALU_NOP));
        check("fence_rw", r.rw, 0);

        // SLL x3,x1,x2 traps after DECODE
        run(32'h002091B3, 0, 0, 1'b0, 0, r);
        check("sll_ill_cyc", r.ill_cyc, 3);
        check("sll_no_retire", r.lat, 0);
        ireq_cnt = 0;
        ill_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #5;
            if (imem_req) ireq_cnt++;
            if (illegal) ill_cnt++;
        end
        check("trap_no_imem_req", ireq_cnt, 0);
        check("trap_illegal_held", ill_cnt, 10);

        // Leave TRAP through reset
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("trap_rst_illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;

        // Store with a long data wait, reset asserted during MEM (cycle 5)
        run(32'h0020A023, 0, 8, 1'b0, 5, r);
        check("mem_rst_was_req", r.dreq, 1);
        @(posedge clk);
        #2;
        check("mem_rst_instr", instr, 32'h0000_0013);
        check("mem_rst_imem_req", 32'(imem_req), 32'd0);
        rst_n = 1'b1;

        // Fresh ADD after the abandoned store
        run(32'h002081B3, 0, 0, 1'b0, 0, r);
        check("post_rst_lat", r.lat, 4);
        check("post_rst_ireq", r.ireq_ok, 1);
        check("post_rst_ir", r.ir_ok, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the single-issue RV32I datapath. It drives instruction and data memory handshakes, latches the fetched instruction, and decodes it into `control_signals_t`. It steps the datapath through FETCH/DECODE/EXECUTE/MEM/WB and tells the PC register when and how to update. It sits between the memory interfaces and the ALU/register-file/immediate-generator datapath, and owns every datapath write enable.

## Interface
Parameters:
- `RESET_IR`, `32'h0000_0013`: instruction-register value held in and after reset (ADDI x0,x0,0).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: instruction fetch request.
- `imem_ready` in 1: fetch completes in any cycle where `imem_req` and `imem_ready` are both 1.
- `imem_rdata` in 32: instruction word, sampled on the fetch handshake.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: 1 = store, 0 = load; valid while `dmem_req` is 1.
- `dmem_ready` in 1: data access completes on `dmem_req` & `dmem_ready`.
- `branch_taken` in 1: comparator result; sampled only in EXECUTE of a BRANCH.
- `instr` out 32: latched instruction register, feeding the immediate generator and register-file addresses.
- `ctrl` out `control_signals_t`: datapath control.
- `pc_we` out 1: PC register update strobe.
- `pc_sel` out `pc_sel_t`: `PC_PLUS4` or `PC_TARGET`; valid while `pc_we` is 1.
- `instret` out 1: one-cycle pulse per retired instruction.
- `illegal` out 1: sticky trap flag.

## Operation
- States (`ctrl_state_t`): FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
- FETCH:
  - `imem_req`=1, held until the handshake completes. Dropping the request before completion is forbidden.
  - On the handshake: IR ← `imem_rdata`, then go to DECODE.
- DECODE (1 cycle):
  - Register `ctrl` from the decoder output.
  - If the decoder flags the instruction illegal, go to TRAP; otherwise go to EXECUTE.
- Decode rules (funct3 = `instr[14:12]`, funct7 bit = `instr[30]`):
  - OP: 000 → ADD, or SUB if funct7 bit = 1; 100 → XOR; 110 → OR; 111 → AND. Source B = RS2.
  - OP_IMM: same funct3 mapping; ADD only (funct7 bit ignored). Source B = IMM, `IMM_I`.
  - LOAD: ADD, IMM, `IMM_I`.
  - STORE: ADD, IMM, `IMM_S`.
  - BRANCH: SUB, RS2, `IMM_B`.
  - MISC_MEM: `ALU_NOP`, treated as a no-op.
  - Illegal: every other opcode, including LUI, AUIPC, JAL, JALR and SYSTEM, and every other funct3 (shifts, SLT, SLTU).
  - Source A is always RS1.
- EXECUTE (1 cycle):
  - LOAD or STORE → MEM.
  - BRANCH → `pc_we`=1, `pc_sel` = `PC_TARGET` if `branch_taken`, else `PC_PLUS4`; `instret`=1; go to FETCH.
  - MISC_MEM → `pc_we`=1, `PC_PLUS4`, `instret`=1; go to FETCH.
  - Otherwise → WB.
- MEM:
  - `dmem_req`=1, held until `dmem_ready`.
  - STORE: `dmem_we`=1; on the handshake, `pc_we`=1, `PC_PLUS4`, `instret`=1, go to FETCH.
  - LOAD: on the handshake, go to WB.
- WB (1 cycle):
  - `ctrl.reg_write` = `WRITE_ENABLE`; `pc_we`=1, `PC_PLUS4`, `instret`=1.
  - Go to FETCH.
- `ctrl.reg_write` is `WRITE_DISABLE` in every state except WB.
- TRAP: absorbing state. `illegal`=1; no requests, no `pc_we`. Only reset leaves TRAP.

## Timing
- Reset values of outputs:
  - `imem_req`, `dmem_req`, `dmem_we`, `pc_we`, `instret`, `illegal` = 0.
  - `ctrl` = `CTRL_NOP`.
  - `instr` = `RESET_IR`.
  - State = FETCH.
- Reset is asynchronous at assertion. `imem_req` rises in the first clock cycle after `rst_n` deasserts.
- Reset mid-transaction: abandon the transaction immediately. There is no retire and no `pc_we`. The memory side must tolerate the dropped request.
- Latency with zero-wait memory (ready=1 while requesting):
  - OP/OP_IMM: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH/MISC_MEM: 3 cycles.
  - Each wait cycle adds 1 cycle.
- `instret` and `pc_we` coincide, and `pc_we` is never 1 for more than 1 cycle per instruction.
- `ctrl` is registered: it is stable from the cycle after DECODE through the last cycle of the instruction, and returns to `CTRL_NOP` in FETCH.
- `imem_rdata` is ignored while `imem_ready` is 0.
- `branch_taken` is ignored outside EXECUTE-of-BRANCH.

## Structure
- Add to `cpu_pkg`:
  - `ctrl_state_t`.
  - `pc_sel_t` (`PC_PLUS4`, `PC_TARGET`).
  - `CTRL_NOP` = {`ALU_NOP`, `SRC_A_RS1`, `SRC_B_RS2`, `IMM_I`, `WRITE_DISABLE`}.
- One sub-module, `instr_decoder`: purely combinational, 32-bit instruction → `control_signals_t` plus `illegal`. Its `reg_write` output is the per-opcode intent; the FSM gates it to WB.

## Test plan
- Zero-wait ADD x3,x1,x2 (0x002081B3) → `ctrl.alu_op`=ALU_ADD, RS2; `reg_write` high exactly in cycle 4; `pc_we` and `instret` high in cycle 4 only.
- FETCH with `imem_ready` low for 3 cycles → `imem_req` stays 1 throughout; IR updates only on the ready cycle; total latency 7 cycles for an OP.
- LW (0x0000A183) with `dmem_ready` delayed 2 cycles → `dmem_req`=1 and `dmem_we`=0 for 3 cycles; WB in cycle 7; `instret` in cycle 7.
- BEQ with `branch_taken`=1, then again with 0 → `pc_sel`=PC_TARGET, then PC_PLUS4; each in cycle 3; `reg_write` never asserted.
- SLL (0x002091B3) → TRAP after DECODE; `illegal`=1 and held; no further `imem_req` until reset.
- `rst_n` low during MEM of a store → `dmem_req` drops asynchronously; no `instret`; after release, FETCH with IR = 0x00000013.
